// File: rtl/eeg_decimator_if.sv
// ADC-side and master-side signal bundle for the EEG boxcar decimator.
// The master modport drives the stimulus; the slave modport belongs to the decimator.
interface eeg_decimator_if #(
  parameter int ADC_DEPTH        = 16,
  parameter int EEG_SAMPLE_DEPTH = 16
);
  logic                        new_sleep_epoch;
  logic                        adc_sample_valid;
  logic [ADC_DEPTH-1:0]        adc_sample;
  logic                        new_eeg_sample;
  logic [EEG_SAMPLE_DEPTH-1:0] eeg_sample;
  logic                        epoch_done;
  logic                        busy;
  logic                        epoch_overrun;

  modport master (
    output new_sleep_epoch,
    output adc_sample_valid,
    output adc_sample,
    input  new_eeg_sample,
    input  eeg_sample,
    input  epoch_done,
    input  busy,
    input  epoch_overrun
  );

  modport slave (
    input  new_sleep_epoch,
    input  adc_sample_valid,
    input  adc_sample,
    output new_eeg_sample,
    output eeg_sample,
    output epoch_done,
    output busy,
    output epoch_overrun
  );
endinterface

// File: rtl/eeg_decimator.sv
// Boxcar decimator: averages groups of 2^DECIM_LOG2 ADC samples and emits
// SAMPLES_PER_EPOCH results per sleep epoch, then returns to idle.
module eeg_decimator #(
  parameter int ADC_DEPTH         = 16,
  parameter int EEG_SAMPLE_DEPTH  = 16,
  parameter int DECIM_LOG2        = 2,
  parameter int SAMPLES_PER_EPOCH = 3840
) (
  input logic             clk,
  input logic             rst_n,
  eeg_decimator_if.slave  bus
);

  localparam int AW = ADC_DEPTH + DECIM_LOG2;
  localparam int SW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int CW = (SAMPLES_PER_EPOCH > 1) ?
                      $clog2(SAMPLES_PER_EPOCH) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'((1 << DECIM_LOG2) - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLES_PER_EPOCH - 1);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_CAPTURE = 1'b1
  } state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [AW-1:0]               r_acc;
  logic [SW-1:0]               r_sub;
  logic [CW-1:0]               r_cnt;
  logic                        r_new;
  logic [EEG_SAMPLE_DEPTH-1:0] r_eeg;
  logic                        r_done;
  logic                        r_ovr;

  logic                        w_cap;
  logic                        w_take;
  logic                        w_last_sub;
  logic                        w_emit;
  logic                        w_done;
  logic                        w_start;
  logic                        w_ovr_set;
  logic [AW-1:0]               w_sum;
  logic [ADC_DEPTH-1:0]        w_avg;

  assign w_sum = r_acc + AW'(bus.adc_sample);
  assign w_avg = w_sum[AW-1:DECIM_LOG2];

  always_ff @(posedge clk) begin
    if (rst_n) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) w_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (w_done && !w_start) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // With no decimation every accepted sample closes its own group.
  always_comb begin
    w_cap      = (r_state == S_CAPTURE);
    w_take     = w_cap && bus.adc_sample_valid;
    w_last_sub = (DECIM_LOG2 == 0) ? 1'b1 : (r_sub == SUB_LAST);
    w_emit     = w_take && w_last_sub;
    w_done     = w_emit && (r_cnt == CNT_LAST);
    w_start    = bus.new_sleep_epoch && (!w_cap || w_done);
    w_ovr_set  = bus.new_sleep_epoch && w_cap && !w_done;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_acc  <= '0;
      r_sub  <= '0;
      r_cnt  <= '0;
      r_new  <= 1'b0;
      r_eeg  <= '0;
      r_done <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_new  <= w_emit;
      r_done <= w_done;
      if (w_emit)    r_eeg <= EEG_SAMPLE_DEPTH'(w_avg);
      if (w_ovr_set) r_ovr <= 1'b1;
      // A start in the completion cycle wins over the counter update.
      if (w_start) begin
        r_acc <= '0;
        r_sub <= '0;
        r_cnt <= '0;
      end else if (w_emit) begin
        r_acc <= '0;
        r_sub <= '0;
        r_cnt <= r_cnt + CW'(1);
      end else if (w_take) begin
        r_acc <= w_sum;
        r_sub <= r_sub + SW'(1);
      end
    end
  end

  assign bus.new_eeg_sample = r_new;
  assign bus.eeg_sample     = r_eeg;
  assign bus.epoch_done     = r_done;
  assign bus.busy           = (r_state == S_CAPTURE);
  assign bus.epoch_overrun  = r_ovr;

endmodule
